// File: rtl/tri_pkg.sv
// Shared types and packing constants for the triangle scheduler.
package tri_pkg;

  localparam int unsigned COORD_W = 3;
  localparam int unsigned VTX_W   = 2 * COORD_W;
  localparam int unsigned TRI_W   = 3 * VTX_W;
  localparam int unsigned V0_OFS  = 0;
  localparam int unsigned V1_OFS  = VTX_W;
  localparam int unsigned V2_OFS  = 2 * VTX_W;
  localparam int unsigned CNT_W   = 7;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;

  typedef enum logic [2:0] {
    IDLE, SORT, FEED0, FEED1, FEED2, WAIT_BUSY, RUN, DONE
  } state_t;

endpackage

// File: rtl/tri_sort3.sv
// Combinational stable sort of three packed vertices by ascending y.
module tri_sort3
  import tri_pkg::*;
(
  input  logic [TRI_W-1:0] tri_in,
  output vertex_t          s0,
  output vertex_t          s1,
  output vertex_t          s2
);

  vertex_t a, b, c, t;

  // Three-stage bubble network; strict compares keep equal-y vertices in input order.
  always_comb begin
    a = vertex_t'(tri_in[V0_OFS +: VTX_W]);
    b = vertex_t'(tri_in[V1_OFS +: VTX_W]);
    c = vertex_t'(tri_in[V2_OFS +: VTX_W]);
    t = a;
    if (a.y > b.y) begin t = a; a = b; b = t; end
    if (b.y > c.y) begin t = b; b = c; c = t; end
    if (a.y > b.y) begin t = a; a = b; b = t; end
    s0 = a;
    s1 = b;
    s2 = c;
  end

endmodule

// File: rtl/tri_sched.sv
// Round-robin two-source scheduler feeding the triangle rasterizer engine.
module tri_sched
  import tri_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic [TRI_W-1:0]   tri_0,
  input  logic [TRI_W-1:0]   tri_1,
  output logic               gnt0,
  output logic               gnt1,
  output logic               done0,
  output logic               done1,
  output logic [CNT_W-1:0]   cnt,
  output logic               err,
  output logic               eng_nt,
  output logic [COORD_W-1:0] eng_xi,
  output logic [COORD_W-1:0] eng_yi,
  input  logic               eng_busy,
  input  logic               eng_po,
  input  logic [COORD_W-1:0] eng_xo,
  input  logic [COORD_W-1:0] eng_yo,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_id
);

  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_t             state_q, state_d;
  logic               last_q, last_d, owner_q, owner_d, win;
  logic [TRI_W-1:0]   tri_q, tri_d;
  vertex_t [2:0]      vtx_q, vtx_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  vertex_t            s0, s1, s2;

  logic               gnt0_d, gnt1_d, done0_d, done1_d, err_d, eng_nt_d;
  logic               pix_valid_d, pix_id_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [COORD_W-1:0] eng_xi_d, eng_yi_d, pix_x_d, pix_y_d;

  tri_sort3 u_sort (
    .tri_in (tri_q),
    .s0     (s0),
    .s1     (s1),
    .s2     (s2)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      tri_q   <= '0;
      vtx_q   <= '0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      tri_q   <= tri_d;
      vtx_q   <= vtx_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  // Next state plus next-cycle values of every registered output.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    tri_d       = tri_q;
    vtx_d       = vtx_q;
    count_d     = count_q;
    timer_d     = timer_q;
    win         = 1'b0;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    cnt_d       = '0;
    err_d       = 1'b0;
    eng_nt_d    = 1'b0;
    eng_xi_d    = '0;
    eng_yi_d    = '0;
    pix_valid_d = 1'b0;
    pix_x_d     = '0;
    pix_y_d     = '0;
    pix_id_d    = 1'b0;

    if ((state_q == WAIT_BUSY || state_q == RUN) && eng_po) begin
      count_d     = count_q + CNT_W'(1);
      pix_valid_d = 1'b1;
      pix_x_d     = eng_xo;
      pix_y_d     = eng_yo;
      pix_id_d    = owner_q;
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          win     = (req0 && req1) ? ~last_q : req1;
          owner_d = win;
          last_d  = win;
          tri_d   = win ? tri_1 : tri_0;
          count_d = '0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          state_d = SORT;
        end
      end
      SORT: begin
        vtx_d[0] = s0;
        vtx_d[1] = s1;
        vtx_d[2] = s2;
        eng_nt_d = 1'b1;
        eng_xi_d = s0.x;
        eng_yi_d = s0.y;
        state_d  = FEED0;
      end
      FEED0: begin
        eng_xi_d = vtx_q[1].x;
        eng_yi_d = vtx_q[1].y;
        state_d  = FEED1;
      end
      FEED1: begin
        eng_xi_d = vtx_q[2].x;
        eng_yi_d = vtx_q[2].y;
        state_d  = FEED2;
      end
      FEED2: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (eng_busy) begin
          state_d = RUN;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      RUN: begin
        if (!eng_busy) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == DONE) begin
      done0_d = ~owner_q;
      done1_d = owner_q;
      cnt_d   = count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      cnt       <= '0;
      err       <= 1'b0;
      eng_nt    <= 1'b0;
      eng_xi    <= '0;
      eng_yi    <= '0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_id    <= 1'b0;
    end else begin
      gnt0      <= gnt0_d;
      gnt1      <= gnt1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      cnt       <= cnt_d;
      err       <= err_d;
      eng_nt    <= eng_nt_d;
      eng_xi    <= eng_xi_d;
      eng_yi    <= eng_yi_d;
      pix_valid <= pix_valid_d;
      pix_x     <= pix_x_d;
      pix_y     <= pix_y_d;
      pix_id    <= pix_id_d;
    end
  end

endmodule

// File: tb/tb_tri_sched.sv
// Directed, table-driven bench for tri_sched with a cycle-stepped engine model.
module tb_tri_sched;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [17:0] tri_0 = '0, tri_1 = '0;
  logic        gnt0, gnt1, done0, done1, err, eng_nt, pix_valid, pix_id;
  logic [6:0]  cnt;
  logic [2:0]  eng_xi, eng_yi, pix_x, pix_y;
  logic        eng_busy = 1'b0, eng_po = 1'b0;
  logic [2:0]  eng_xo = '0, eng_yo = '0;
  logic [26:0] all_out;

  int errors = 0;
  int checks = 0;

  assign all_out = {gnt0, gnt1, done0, done1, cnt, err, eng_nt, eng_xi, eng_yi,
                    pix_valid, pix_x, pix_y, pix_id};

  always #5 clk = ~clk;

  tri_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .tri_0(tri_0), .tri_1(tri_1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .cnt(cnt), .err(err),
    .eng_nt(eng_nt), .eng_xi(eng_xi), .eng_yi(eng_yi), .eng_busy(eng_busy),
    .eng_po(eng_po), .eng_xo(eng_xo), .eng_yo(eng_yo), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_id(pix_id)
  );

  typedef struct {
    logic        r0, r1;
    logic [17:0] t0, t1;
    logic        own;
    logic [17:0] exp;
    int          bd, bl, npix;
    logic        po_feed;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [17:0] mk(input int x0, y0, x1, y1, x2, y2);
    return {3'(x2), 3'(y2), 3'(x1), 3'(y1), 3'(x0), 3'(y0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset_outputs", 32'(all_out), 0);
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One full service: request, grant, feed, engine activity (bd<0 = never busy), done.
  task automatic run_txn(input logic r0, r1, input logic [17:0] t0, t1, input logic own,
                         input logic [17:0] exp_sorted, input int bd, bl, npix,
                         input logic po_feed);
    int          done_i, k, exp_cnt;
    logic        tmo, prev_po;
    logic [2:0]  prev_x, prev_y;
    logic [5:0]  ev;
    tmo    = (bd < 0);
    done_i = tmo ? TO : bd + bl + 1;
    req0 = r0; req1 = r1; tri_0 = t0; tri_1 = t1;
    tick();
    check("gnt0", 32'(gnt0), 32'(!own));
    check("gnt1", 32'(gnt1), 32'(own));
    if (own) req1 = 1'b0; else req0 = 1'b0;
    for (int f = 0; f < 3; f++) begin
      eng_po = po_feed; eng_xo = 3'd5; eng_yo = 3'd2;
      tick();
      ev = exp_sorted[6*f +: 6];
      check("eng_nt", 32'(eng_nt), 32'(f == 0));
      check("eng_xi", 32'(eng_xi), 32'(ev[5:3]));
      check("eng_yi", 32'(eng_yi), 32'(ev[2:0]));
      check("pix_ignored_feed", 32'(pix_valid), 0);
    end
    eng_po = po_feed;
    tick();
    check("eng_idle_zero", 32'({eng_nt, eng_xi, eng_yi}), 0);
    check("pix_ignored_feed2", 32'(pix_valid), 0);
    eng_po = 1'b0;
    k = 0; exp_cnt = 0; prev_po = 1'b0; prev_x = '0; prev_y = '0;
    for (int i = 0; i <= done_i; i++) begin
      check("pix_valid", 32'(pix_valid), 32'(prev_po));
      if (prev_po) begin
        check("pix_x", 32'(pix_x), 32'(prev_x));
        check("pix_y", 32'(pix_y), 32'(prev_y));
        check("pix_id", 32'(pix_id), 32'(own));
      end
      if (i == done_i) begin
        check("done_owner", 32'(own ? done1 : done0), 1);
        check("done_other", 32'(own ? done0 : done1), 0);
        check("cnt", 32'(cnt), 32'(exp_cnt));
        check("err", 32'(err), 32'(tmo));
      end else if (done0 || done1 || cnt != 0) begin
        check("done_early", 32'({done0, done1, cnt}), 0);
      end
      eng_busy = !tmo && (i >= bd) && (i < bd + bl);
      eng_po   = (i < done_i) && (i % 3 == 1) && (k < npix);
      if (eng_po) begin
        eng_xo = 3'(k); eng_yo = 3'(7 - k);
        k++; exp_cnt++;
      end
      prev_po = eng_po; prev_x = eng_xo; prev_y = eng_yo;
      tick();
    end
    eng_busy = 1'b0; eng_po = 1'b0;
    check("done_cleared", 32'({done0, done1, cnt, err}), 0);
  endtask

  initial begin
    #2;
    do_reset();

    // Simultaneous requests after reset: 0 first, then the held 1 wins the re-raised tie.
    run_txn(1, 1, mk(4,5, 2,3, 7,1), mk(1,1, 1,0, 6,7), 0, mk(7,1, 2,3, 4,5), 1, 5, 10, 0);
    run_txn(1, 1, mk(4,5, 2,3, 7,1), mk(1,1, 1,0, 6,7), 1, mk(1,0, 1,1, 6,7), 0, 4, 10, 0);
    run_txn(1, 1, mk(0,2, 0,1, 0,0), mk(1,1, 1,0, 6,7), 0, mk(0,0, 0,1, 0,2), 0, 3, 10, 0);

    do_reset();
    vecs[0] = '{1'b1, 1'b0, mk(0,7, 0,0, 3,3), 18'd0, 1'b0, mk(0,0, 3,3, 0,7), 2, 6, 10, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 18'd0, mk(1,2, 5,2, 1,6), 1'b1, mk(1,2, 5,2, 1,6), 0, 5, 10, 1'b0};
    vecs[2] = '{1'b1, 1'b1, mk(4,5, 2,3, 7,1), mk(6,4, 3,4, 5,4), 1'b0, mk(7,1, 2,3, 4,5),
                0, 30, 10, 1'b0};
    vecs[3] = '{1'b1, 1'b1, mk(4,5, 2,3, 7,1), mk(6,4, 3,4, 5,4), 1'b1, mk(6,4, 3,4, 5,4),
                3, 9, 10, 1'b1};
    vecs[4] = '{1'b1, 1'b0, mk(1,1, 2,2, 3,3), 18'd0, 1'b0, mk(1,1, 2,2, 3,3), -1, 0, 0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 18'd0, mk(7,7, 6,6, 5,5), 1'b1, mk(5,5, 6,6, 7,7), -1, 0, 3, 1'b0};
    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].r0, vecs[v].r1, vecs[v].t0, vecs[v].t1, vecs[v].own, vecs[v].exp,
              vecs[v].bd, vecs[v].bl, vecs[v].npix, vecs[v].po_feed);

    // Reset in the middle of RUN after four pixels, then stray engine pixels.
    req0 = 1'b1; tri_0 = mk(2,1, 4,3, 6,5);
    tick();
    req0 = 1'b0;
    repeat (4) tick();
    eng_busy = 1'b1;
    for (int j = 0; j < 8; j++) begin
      eng_po = (j % 2 == 1); eng_xo = 3'(j); eng_yo = 3'(j);
      tick();
    end
    check("pre_reset_pix", 32'(pix_valid), 1);
    eng_po = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("midrun_reset_outputs", 32'(all_out), 0);
    tick();
    tick();
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      eng_po = 1'b1;
      tick();
      check("stray_po_outputs", 32'(all_out), 0);
    end
    eng_po = 1'b0; eng_busy = 1'b0;
    tick();
    run_txn(0, 1, 18'd0, mk(3,6, 2,5, 1,4), 1, mk(1,4, 2,5, 3,6), 1, 4, 10, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
